// File: rtl/rr_arbiter8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb_pkg : shared types/constants for the 8-way RR arbiter. r1.0 |
// +--------------------------------------------------------------------+
package rr_arb_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter8_if : request/grant bundle of the arbiter.         r1.0 |
// +--------------------------------------------------------------------+
interface rr_arbiter8_if;
  import rr_arb_pkg::*;

  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (output req, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick8 : rotating-priority 8:3 winner select (combinational). r1.0|
// +--------------------------------------------------------------------+
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_req_o
);

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;

  // Doubling the vector turns the rotate into a plain right shift.
  assign w_dbl = {req_i, req_i} >> ptr_i;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign win_idx_o = w_off + ptr_i;
  assign any_req_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter8 : 8-requester round-robin arbiter with hold timeout.r1.0|
// +--------------------------------------------------------------------+
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave arb_io
);

  localparam logic [CNT_W-1:0] C_MAX_HOLD = CNT_W'(MAX_HOLD);

  state_e           state_q;
  logic [N-1:0]     gnt_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             gnt_valid_q;
  logic             timeout_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic [IDX_W-1:0] w_win_idx;
  logic             w_any_req;
  logic             w_owner_req;
  logic             w_timed_out;

  rr_pick8 u_pick (
    .req_i     (arb_io.req),
    .ptr_i     (ptr_q),
    .win_idx_o (w_win_idx),
    .any_req_o (w_any_req)
  );

  assign w_owner_req = arb_io.req[gnt_idx_q];
  assign w_timed_out = (MAX_HOLD != 0) && (hold_cnt_q == C_MAX_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_any_req) begin
            state_q     <= GRANT;
            gnt_q       <= onehot(w_win_idx);
            gnt_idx_q   <= w_win_idx;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= CNT_W'(1);
          end
        end
        GRANT: begin
          // gnt_idx is kept on release; only gnt/gnt_valid drop.
          if (!w_owner_req || w_timed_out) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + IDX_W'(1);
            hold_cnt_q  <= '0;
            timeout_q   <= w_owner_req;
          end else if (hold_cnt_q != '1) begin
            hold_cnt_q  <= hold_cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign arb_io.gnt       = gnt_q;
  assign arb_io.gnt_idx   = gnt_idx_q;
  assign arb_io.gnt_valid = gnt_valid_q;
  assign arb_io.timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rr_arbiter8 : scoreboard bench, MAX_HOLD=16 and MAX_HOLD=4. r1.0|
// +--------------------------------------------------------------------+
module tb_rr_arbiter8;

  localparam int C_MAXH0 = 16;
  localparam int C_MAXH1 = 4;

  typedef struct packed {
    logic       valid;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;

  int checks   = 0;
  int failures = 0;

  rr_arbiter8_if if0 ();
  rr_arbiter8_if if1 ();
  assign if0.req = req;
  assign if1.req = req;

  rr_arbiter8 #(.MAX_HOLD(C_MAXH0), .CNT_W(5)) dut0 (.clk(clk), .rst(rst), .arb_io(if0));
  rr_arbiter8 #(.MAX_HOLD(C_MAXH1), .CNT_W(5)) dut1 (.clk(clk), .rst(rst), .arb_io(if1));

  always #5 clk = ~clk;

  // Reference model: owner as an int (-1 = none), plain modular search.
  int   m_owner[2];
  int   m_hold[2];
  int   m_ptr[2];
  int   m_last[2];
  bit   m_to[2];
  exp_t q0[$];
  exp_t q1[$];

  function automatic int maxh(input int d);
    return (d == 0) ? C_MAXH0 : C_MAXH1;
  endfunction

  task automatic model_reset(input int d);
    m_owner[d] = -1;
    m_hold[d]  = 0;
    m_ptr[d]   = 0;
    m_last[d]  = 0;
    m_to[d]    = 1'b0;
  endtask

  task automatic model_step(input int d, input logic [7:0] r, output exp_t e);
    m_to[d] = 1'b0;
    if (m_owner[d] < 0) begin
      for (int i = 0; i < 8; i++) begin
        int k;
        k = (m_ptr[d] + i) % 8;
        if (r[k] && m_owner[d] < 0) begin
          m_owner[d] = k;
          m_last[d]  = k;
          m_hold[d]  = 1;
        end
      end
    end else if (!r[m_owner[d]]) begin
      m_ptr[d]   = (m_owner[d] + 1) % 8;
      m_owner[d] = -1;
    end else if (maxh(d) != 0 && m_hold[d] == maxh(d)) begin
      m_ptr[d]   = (m_owner[d] + 1) % 8;
      m_owner[d] = -1;
      m_to[d]    = 1'b1;
    end else begin
      m_hold[d]  = m_hold[d] + 1;
    end
    e.valid = (m_owner[d] >= 0);
    e.gnt   = e.valid ? 8'(1 << m_owner[d]) : 8'h00;
    e.idx   = 3'(m_last[d]);
    e.to    = m_to[d];
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      model_reset(0);
      model_reset(1);
      e = '0;
      q0.push_back(e);
      q1.push_back(e);
    end else begin
      model_step(0, req, e);
      q0.push_back(e);
      model_step(1, req, e);
      q1.push_back(e);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req_v, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle per DUT, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() == 0 || q1.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=%0d/%0d required=nonzero", q0.size(), q1.size());
    end else begin
      e = q0.pop_front();
      cmp("d0_gnt_valid", 32'(if0.gnt_valid), 32'(e.valid));
      cmp("d0_gnt",       32'(if0.gnt),       32'(e.gnt));
      cmp("d0_gnt_idx",   32'(if0.gnt_idx),   32'(e.idx));
      cmp("d0_timeout",   32'(if0.timeout),   32'(e.to));
      e = q1.pop_front();
      cmp("d1_gnt_valid", 32'(if1.gnt_valid), 32'(e.valid));
      cmp("d1_gnt",       32'(if1.gnt),       32'(e.gnt));
      cmp("d1_gnt_idx",   32'(if1.gnt_idx),   32'(e.idx));
      cmp("d1_timeout",   32'(if1.timeout),   32'(e.to));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] r, input int n);
    req = r;
    tick(n);
  endtask

  // Reset asserted between edges: outputs must clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    cmp("async_gnt",     32'({if0.gnt, if1.gnt}),             32'h0);
    cmp("async_valid",   32'({if0.gnt_valid, if1.gnt_valid}), 32'h0);
    cmp("async_timeout", 32'({if0.timeout, if1.timeout}),     32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;

    drive(8'hFF, 5);
    async_reset();
    drive(8'hFF, 3);
    drive(8'h00, 3);

    drive(8'h10, 4);
    drive(8'h00, 3);

    for (int i = 0; i < 24; i++) begin
      req = 8'hFF & ~if0.gnt;
      tick(1);
    end
    drive(8'h00, 3);

    async_reset();
    drive(8'h20, 2);
    drive(8'h00, 2);
    drive(8'h41, 6);
    drive(8'h01, 4);
    drive(8'h00, 3);

    drive(8'h04, 14);
    drive(8'h00, 3);

    drive(8'h08, 2);
    for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? 8'hF8 : 8'h08, 1);
    drive(8'h00, 3);

    drive(8'h01, 40);
    drive(8'h00, 3);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       req = 8'($urandom);
        3:       req = req & 8'($urandom);
        default: req = req;
      endcase
      if (i == 200) async_reset();
      tick(1);
    end
    drive(8'h00, 3);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
